// File: rtl/data_mem_copy_engine_pkg.sv
// Package dmem_pkg: shared types and constants for the data memory copy engine.
//   MEM_BASE / MEM_TOP : legal data RAM address window
//   addr_t             : 8-bit data memory address
//   state_t            : copy engine FSM states
package dmem_pkg;

  localparam int unsigned MEM_BASE = 64;
  localparam int unsigned MEM_TOP  = 127;

  typedef logic [7:0] addr_t;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    RD,
    WR,
    DONE
  } state_t;

endpackage

// File: rtl/data_mem_copy_engine_range_check.sv
// dmem_range_check: combinational window check for one block of bytes.
//   base_i     : first byte address of the block
//   len_i      : byte count (block assumed non-empty by the caller)
//   in_range_o : 1 when base_i .. base_i+len_i-1 lies within BASE..TOP
// The end address is formed in 9 bits so blocks running past 255 are caught.
module dmem_range_check
  import dmem_pkg::*;
#(
  parameter int unsigned BASE  = MEM_BASE,
  parameter int unsigned TOP   = MEM_TOP,
  parameter int unsigned LEN_W = 7
) (
  input  addr_t            base_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             in_range_o
);

  logic [8:0] last;

  always_comb begin
    last       = {1'b0, base_i} + 9'(len_i) - 9'd1;
    in_range_o = ({1'b0, base_i} >= 9'(BASE)) && (last <= 9'(TOP));
  end

endmodule

// File: rtl/data_mem_copy_engine.sv
// data_mem_copy_engine: ascending byte block copy inside the data RAM window.
// Ports:
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   start           : one-cycle request, accepted only in IDLE
//   src_addr/dst_addr/len : block description latched on an accepted start
//   read_data       : registered RAM read data (valid the cycle after a read)
//   data_address, write_data, write_enable : RAM initiator port
//   busy, done, error : status; done/error are one-cycle pulses
//   checksum        : modulo-256 sum of written bytes (DATA_MEM_COPY_CHECKSUM_EN only)
// Optional feature macro: DATA_MEM_COPY_CHECKSUM_EN.
module data_mem_copy_engine
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_BASE = dmem_pkg::MEM_BASE,
  parameter int unsigned MEM_TOP  = dmem_pkg::MEM_TOP,
  parameter int unsigned LEN_W    = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       src_addr,
  input  logic [7:0]       dst_addr,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       read_data,
  output logic [7:0]       data_address,
  output logic [7:0]       write_data,
  output logic             write_enable,
  output logic             busy,
  output logic             done,
  output logic             error
`ifdef DATA_MEM_COPY_CHECKSUM_EN
  ,
  output logic [7:0]       checksum
`endif
);

  state_t           state_q, state_d;
  addr_t            src_q, dst_q;
  logic [LEN_W-1:0] rem_q;
  logic             src_ok, dst_ok;
  logic             accept;

  assign accept = (state_q == IDLE) && start;

  dmem_range_check #(.BASE(MEM_BASE), .TOP(MEM_TOP), .LEN_W(LEN_W)) u_src_chk (
    .base_i    (src_q),
    .len_i     (rem_q),
    .in_range_o(src_ok)
  );

  dmem_range_check #(.BASE(MEM_BASE), .TOP(MEM_TOP), .LEN_W(LEN_W)) u_dst_chk (
    .base_i    (dst_q),
    .len_i     (rem_q),
    .in_range_o(dst_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A zero-length request still passes through DONE so its latency matches 2+2*len.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = CHECK;
      CHECK: begin
        if (rem_q == '0)            state_d = DONE;
        else if (!(src_ok && dst_ok)) state_d = IDLE;
        else                        state_d = RD;
      end
      RD:    state_d = WR;
      WR:    state_d = (rem_q == LEN_W'(1)) ? DONE : RD;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode the state directly so reset forces write_enable low at once.
  always_comb begin
    data_address = '0;
    write_data   = '0;
    write_enable = 1'b0;
    done         = 1'b0;
    error        = 1'b0;
    busy         = (state_q != IDLE);
    unique case (state_q)
      CHECK: error = (rem_q != '0) && !(src_ok && dst_ok);
      RD:    data_address = src_q;
      WR: begin
        data_address = dst_q;
        write_data   = read_data;
        write_enable = 1'b1;
      end
      DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q <= '0;
      dst_q <= '0;
      rem_q <= '0;
    end else if (accept) begin
      src_q <= src_addr;
      dst_q <= dst_addr;
      rem_q <= len;
    end else if (state_q == WR) begin
      src_q <= src_q + 8'd1;
      dst_q <= dst_q + 8'd1;
      rem_q <= rem_q - LEN_W'(1);
    end
  end

`ifdef DATA_MEM_COPY_CHECKSUM_EN
  logic [7:0] checksum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               checksum_q <= '0;
    else if (accept)          checksum_q <= '0;
    else if (state_q == WR)   checksum_q <= checksum_q + read_data;
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_data_mem_copy_engine.sv
// Self-checking bench for data_mem_copy_engine with a behavioural RAM and a
// sequential-copy reference model.
module tb_data_mem_copy_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] src_addr = '0;
  logic [7:0] dst_addr = '0;
  logic [6:0] len = '0;
  logic [7:0] read_data;
  logic [7:0] data_address, write_data;
  logic       write_enable, busy, done, error;
`ifdef DATA_MEM_COPY_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] mem      [256];
  logic [7:0] ref_mem  [256];
  logic [7:0] load_img [256];
  logic       load_req = 1'b0;

  always #5 clk = ~clk;

  data_mem_copy_engine #(.MEM_BASE(64), .MEM_TOP(127), .LEN_W(7)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .src_addr    (src_addr),
    .dst_addr    (dst_addr),
    .len         (len),
    .read_data   (read_data),
    .data_address(data_address),
    .write_data  (write_data),
    .write_enable(write_enable),
    .busy        (busy),
    .done        (done),
    .error       (error)
`ifdef DATA_MEM_COPY_CHECKSUM_EN
    ,
    .checksum    (checksum)
`endif
  );

  // Synchronous RAM with registered read, plus a whole-image backdoor load.
  always @(posedge clk) begin
    if (load_req)          mem <= load_img;
    else if (write_enable) mem[data_address] <= write_data;
    read_data <= mem[data_address];
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic load_mem();
    load_img = ref_mem;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic randomize_window();
    for (int i = 64; i < 128; i++) ref_mem[i] = 8'($urandom);
  endtask

  // Reference: legal if empty or both byte ranges inside 64..127; bytes are
  // moved one at a time in ascending order, so overlapping copies propagate.
  task automatic model(input int s, input int d, input int l,
                       output bit err, output int lat, output logic [7:0] sum);
    logic [7:0] v;
    err = (l != 0) && (s < 64 || s + l - 1 > 127 || d < 64 || d + l - 1 > 127);
    lat = err ? 1 : 2 + 2 * l;
    sum = '0;
    if (!err)
      for (int i = 0; i < l; i++) begin
        v = ref_mem[s + i];
        ref_mem[d + i] = v;
        sum += v;
      end
  endtask

  task automatic run_copy(input string tag, input int s, input int d, input int l,
                          input bit exp_err, input int exp_lat,
                          input logic [7:0] exp_sum, input int poke_k);
    int lat, we_cnt, bad;
    bit err;
    logic [7:0] cs_end;
    start    = 1'b1;
    src_addr = 8'(s);
    dst_addr = 8'(d);
    len      = 7'(l);
    @(negedge clk);
    start  = 1'b0;
    lat    = -1;
    err    = 1'b0;
    we_cnt = 0;
    cs_end = '0;
    for (int k = 1; k <= 300; k++) begin
      start = (k == poke_k);
      if (k == poke_k) begin
        src_addr = 8'd64;
        dst_addr = 8'd64;
        len      = 7'd1;
      end
      if (write_enable) we_cnt++;
`ifdef DATA_MEM_COPY_CHECKSUM_EN
      cs_end = checksum;
`endif
      if (error) begin err = 1'b1; lat = k; break; end
      if (done)  begin lat = k; break; end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " error"}, int'(err), int'(exp_err));
    check({tag, " writes"}, we_cnt, exp_err ? 0 : l);
`ifdef DATA_MEM_COPY_CHECKSUM_EN
    check({tag, " checksum"}, int'(cs_end), int'(exp_sum));
`else
    cs_end = exp_sum;
`endif
    @(negedge clk);
    check({tag, " idle after"}, int'({busy, done, error, write_enable}), 0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    check({tag, " mem bytes wrong"}, bad, 0);
  endtask

  typedef struct {
    int                s, d, l, npre;
    logic [3:0][7:0]   pre;
    bit                exp_err;
    int                exp_lat;
  } vec_t;

  function automatic vec_t mk(input int s, d, l, npre, input logic [31:0] pre,
                              input bit e, input int lat);
    vec_t v;
    v.s = s; v.d = d; v.l = l; v.npre = npre; v.pre = pre;
    v.exp_err = e; v.exp_lat = lat;
    return v;
  endfunction

  initial begin
    #3000000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [12];
    bit          e;
    int          lat, wrs, ndone, s, d, l;
    logic [7:0]  sum;

    tbl[0]  = mk(64, 100, 4, 4, 32'h2C21160B, 1'b0, 10);
    tbl[1]  = mk(64, 64, 0, 0, 32'h0, 1'b0, 2);
    tbl[2]  = mk(120, 64, 10, 0, 32'h0, 1'b1, 1);
    tbl[3]  = mk(64, 65, 2, 3, 32'h00030201, 1'b0, 6);
    tbl[4]  = mk(64, 64, 64, 0, 32'h0, 1'b0, 130);
    tbl[5]  = mk(127, 64, 1, 0, 32'h0, 1'b0, 4);
    tbl[6]  = mk(63, 64, 1, 0, 32'h0, 1'b1, 1);
    tbl[7]  = mk(64, 127, 2, 0, 32'h0, 1'b1, 1);
    tbl[8]  = mk(200, 64, 0, 0, 32'h0, 1'b0, 2);
    tbl[9]  = mk(70, 80, 2, 2, 32'h000002FF, 1'b0, 6);
    tbl[10] = mk(64, 96, 64, 0, 32'h0, 1'b1, 1);
    tbl[11] = mk(64, 80, 20, 0, 32'h0, 1'b0, 42);

    #1;
    check("reset outputs", int'({data_address, write_data, write_enable, busy, done, error}), 0);
`ifdef DATA_MEM_COPY_CHECKSUM_EN
    check("reset checksum", int'(checksum), 0);
`endif
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    load_mem();
    check("idle outputs", int'({data_address, write_data, write_enable, busy, done, error}), 0);

    for (int i = 0; i < 12; i++) begin
      randomize_window();
      for (int j = 0; j < tbl[i].npre; j++) ref_mem[tbl[i].s + j] = tbl[i].pre[j];
      load_mem();
      model(tbl[i].s, tbl[i].d, tbl[i].l, e, lat, sum);
      run_copy($sformatf("vec%0d", i), tbl[i].s, tbl[i].d, tbl[i].l,
               tbl[i].exp_err, tbl[i].exp_lat, sum, 0);
      if (i == 0) check("vec0 dst bytes", int'({mem[100], mem[101], mem[102], mem[103]}), 32'h0B16212C);
      if (i == 3) check("overlap dst bytes", int'({mem[65], mem[66]}), 16'h0101);
`ifdef DATA_MEM_COPY_CHECKSUM_EN
      if (i == 9) check("checksum FF+02", int'(checksum), 8'h01);
`endif
    end

    // start pulse while busy must be ignored
    randomize_window();
    load_mem();
    model(64, 100, 8, e, lat, sum);
    run_copy("start while busy", 64, 100, 8, 1'b0, 18, sum, 5);

    // reset during the third write of an 8-byte copy
    randomize_window();
    load_mem();
    model(64, 90, 2, e, lat, sum);
    start = 1'b1; src_addr = 8'd64; dst_addr = 8'd90; len = 7'd8;
    @(negedge clk);
    start = 1'b0;
    wrs = 0;
    for (int k = 0; k < 40; k++) begin
      if (write_enable) wrs++;
      if (wrs == 3) break;
      @(negedge clk);
    end
    check("reach third write", wrs, 3);
    rst_n = 1'b0;
    #1;
    check("async reset outputs", int'({write_enable, busy, done}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      if (done || busy || write_enable) ndone++;
      @(negedge clk);
    end
    check("no activity after reset", ndone, 0);
`ifdef DATA_MEM_COPY_CHECKSUM_EN
    check("checksum after reset", int'(checksum), 0);
`endif
    wrs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) wrs++;
    check("partial copy bytes wrong", wrs, 0);
    model(70, 110, 5, e, lat, sum);
    run_copy("copy after reset", 70, 110, 5, e, lat, sum, 0);

    for (int n = 0; n < 30; n++) begin
      s = int'($urandom_range(56, 135));
      d = int'($urandom_range(56, 135));
      l = int'($urandom_range(0, 64));
      randomize_window();
      load_mem();
      model(s, d, l, e, lat, sum);
      run_copy($sformatf("rand%0d s=%0d d=%0d l=%0d", n, s, d, l), s, d, l, e, lat, sum, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
